// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU branch-trace capture block.
//   trace_kind_e   : kind field of a trace entry (BR_FWD, BR_BACK, REGWR)
//   trace_entry_s  : {kind[1:0], cycle[15:0], from_pc[15:0], to_pc[15:0]}
//   trace_state_e  : capture FSM states
//   is_discontinuity() : true when pc is neither a stall nor pc+1 of prev_pc
package cpu_trace_pkg;

  localparam int TRACE_ENTRY_W = 50;
  localparam int TS_W          = 16;

  typedef enum logic [1:0] {
    BR_FWD  = 2'd0,
    BR_BACK = 2'd1,
    REGWR   = 2'd2
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e kind;
    logic [15:0] cycle;
    logic [15:0] from_pc;
    logic [15:0] to_pc;
  } trace_entry_s;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } trace_state_e;

  // 16-bit compare, so 0xFFFF -> 0x0000 is treated as sequential
  function automatic logic is_discontinuity(input logic [15:0] prev_pc,
                                            input logic [15:0] pc);
    return (pc != prev_pc) && (pc != (prev_pc + 16'd1));
  endfunction

endpackage

// File: rtl/cpu_trace_fifo.sv
// Small synchronous FIFO with push/full on the write side and valid/yumi on
// the read side.
//   clk_i, reset      : clock, asynchronous active-high reset
//   push_i, data_i    : write request and data; accepted when not full, or
//                       when full and the head is taken in the same cycle
//   full_o            : FIFO holds DEPTH entries
//   valid_o, data_o   : head entry; data_o is zero when empty
//   yumi_i            : consumer takes the head; ignored when empty
//   count_o           : occupied entries
module cpu_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 50
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  input  logic                     yumi_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_ok_s;

  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop_s     = yumi_i && !empty_s;
  // When full, the same-cycle pop frees the slot the push lands in
  assign push_ok_s = push_i && (!full_s || pop_s);

  assign wr_ptr_d  = push_ok_s ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
  assign rd_ptr_d  = pop_s     ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;

  assign full_o    = full_s;
  assign valid_o   = !empty_s;
  assign data_o    = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
  assign count_o   = wr_ptr_q - rd_ptr_q;

  // Pointer registers
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/cpu_trace_capture.sv
// Samples the CPU PC every cycle, detects control-flow discontinuities and
// logs each as a timestamped entry in a FIFO drained over valid/yumi.
//   clk_i, reset   : clock, asynchronous active-high reset
//   trace_en_i     : capture enable (FIFO keeps draining when low)
//   pc_i           : CPU program counter
//   rd_i, rd_val_i, rd_we_i : register writeback (used with TRACE_REGWR_EN)
//   entry_v_o, entry_o, entry_yumi_i : head-of-FIFO stream
//   count_o        : occupied entries
//   overflow_o     : sticky, set once any entry was dropped
//   drop_cnt_o     : dropped entries, saturating at 255
// Optional feature macro: TRACE_REGWR_EN (also log register writebacks as
// REGWR entries through a one-entry skid register).
module cpu_trace_capture
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      reset,
  input  logic                      trace_en_i,
  input  logic [15:0]               pc_i,
  input  logic [3:0]                rd_i,
  input  logic [15:0]               rd_val_i,
  input  logic                      rd_we_i,
  output logic                      entry_v_o,
  output logic [TRACE_ENTRY_W-1:0]  entry_o,
  input  logic                      entry_yumi_i,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      overflow_o,
  output logic [7:0]                drop_cnt_o
);

  trace_state_e   state_q, state_d;
  logic [15:0]    prev_pc_q, prev_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;

  logic           capture_s;
  logic           br_v_s;
  trace_entry_s   br_entry_s;
  logic           push_v_s;
  trace_entry_s   push_entry_s;
  logic           rw_drop_s;
  logic           fifo_full_s;
  logic           fifo_drop_s;
  logic [8:0]     drop_sum_s;

  // FSM next state, prev_pc tracking and cycle counter
  always_comb begin
    state_d   = state_q;
    prev_pc_d = prev_pc_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = trace_en_i ? ST_ARM : ST_IDLE;
      end
      ST_ARM: begin
        prev_pc_d = pc_i;
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        prev_pc_d = pc_i;
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = trace_en_i ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Classifier: only a running, enabled capture logs anything
  assign capture_s = (state_q == ST_RUN) && trace_en_i;
  assign br_v_s    = capture_s && is_discontinuity(prev_pc_q, pc_i);

  // Branch entry fields; timestamp is the counter in the sampling cycle
  always_comb begin
    br_entry_s         = '0;
    br_entry_s.kind    = (pc_i > prev_pc_q) ? BR_FWD : BR_BACK;
    br_entry_s.cycle   = TS_W'(cnt_q);
    br_entry_s.from_pc = prev_pc_q;
    br_entry_s.to_pc   = pc_i;
  end

`ifdef TRACE_REGWR_EN
  logic         rw_v_s;
  trace_entry_s rw_entry_s;
  logic         skid_v_q, skid_v_d;
  trace_entry_s skid_q, skid_d;

  assign rw_v_s = capture_s && rd_we_i;

  // Register-write entry fields
  always_comb begin
    rw_entry_s         = '0;
    rw_entry_s.kind    = REGWR;
    rw_entry_s.cycle   = TS_W'(cnt_q);
    rw_entry_s.from_pc = {12'b0, rd_i};
    rw_entry_s.to_pc   = rd_val_i;
  end

  // One push per cycle: branch first, then a parked regwrite, then a fresh one
  always_comb begin
    push_v_s     = 1'b0;
    push_entry_s = '0;
    skid_v_d     = skid_v_q;
    skid_d       = skid_q;
    rw_drop_s    = 1'b0;
    if (br_v_s) begin
      push_v_s     = 1'b1;
      push_entry_s = br_entry_s;
      if (rw_v_s && skid_v_q) begin
        rw_drop_s = 1'b1;
      end else if (rw_v_s) begin
        skid_v_d = 1'b1;
        skid_d   = rw_entry_s;
      end else begin
        skid_v_d = skid_v_q;
      end
    end else if (skid_v_q) begin
      push_v_s     = 1'b1;
      push_entry_s = skid_q;
      skid_v_d     = rw_v_s;
      skid_d       = rw_v_s ? rw_entry_s : skid_q;
    end else if (rw_v_s) begin
      push_v_s     = 1'b1;
      push_entry_s = rw_entry_s;
    end else begin
      push_v_s = 1'b0;
    end
  end

  // Skid register
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      skid_v_q <= 1'b0;
      skid_q   <= '0;
    end else begin
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
    end
  end
`else
  logic unused_regwr_s;
  assign unused_regwr_s = ^{rd_i, rd_val_i, rd_we_i};

  // Only branch entries are produced in this build
  always_comb begin
    push_v_s     = br_v_s;
    push_entry_s = br_entry_s;
    rw_drop_s    = 1'b0;
  end
`endif

  // A push onto a full FIFO is lost unless the head leaves in the same cycle
  assign fifo_drop_s = push_v_s && fifo_full_s && !entry_yumi_i;
  assign drop_sum_s  = {1'b0, drop_cnt_q} + {8'b0, fifo_drop_s} + {8'b0, rw_drop_s};

  // Sticky overflow flag and saturating drop counter
  always_comb begin
    overflow_d = overflow_q | fifo_drop_s | rw_drop_s;
    drop_cnt_d = (drop_sum_s > 9'd255) ? 8'd255 : drop_sum_s[7:0];
  end

  // State, prev_pc, counter and drop bookkeeping registers
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prev_pc_q  <= 16'd0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      prev_pc_q  <= prev_pc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

  cpu_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset   (reset),
    .push_i  (push_v_s),
    .data_i  (push_entry_s),
    .full_o  (fifo_full_s),
    .valid_o (entry_v_o),
    .data_o  (entry_o),
    .yumi_i  (entry_yumi_i),
    .count_o (count_o)
  );

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Self-checking bench for cpu_trace_capture: directed scenarios followed by
// randomized PC/enable/yumi traffic, every cycle compared against a queue-
// based reference model of the trace stream.
module tb_cpu_trace_capture;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          reset;
  logic          trace_en_i;
  logic [15:0]   pc_i;
  logic [3:0]    rd_i;
  logic [15:0]   rd_val_i;
  logic          rd_we_i;
  logic          entry_v_o;
  logic [49:0]   entry_o;
  logic          entry_yumi_i;
  logic [CW-1:0] count_o;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;

  always #5 clk_i = ~clk_i;

  cpu_trace_capture #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .trace_en_i   (trace_en_i),
    .pc_i         (pc_i),
    .rd_i         (rd_i),
    .rd_val_i     (rd_val_i),
    .rd_we_i      (rd_we_i),
    .entry_v_o    (entry_v_o),
    .entry_o      (entry_o),
    .entry_yumi_i (entry_yumi_i),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: capture mode (0 idle, 1 arming, 2 running), last PC,
  // timestamp, FIFO contents as a queue, drop bookkeeping, parked regwrite.
  int          m_mode;
  logic [15:0] m_prev;
  logic [15:0] m_cnt;
  logic [49:0] m_q[$];
  bit          m_ovf;
  int          m_drop;
  bit          m_skid_v;
  logic [49:0] m_skid;
  logic [15:0] last_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev = 16'd0; m_cnt = 16'd0;
    m_q.delete(); m_ovf = 1'b0; m_drop = 0; m_skid_v = 1'b0; m_skid = '0;
  endtask

  task automatic model_push(input logic [49:0] e);
    if (m_q.size() < DEPTH) m_q.push_back(e);
    else begin m_ovf = 1'b1; m_drop++; end
  endtask

  task automatic model_cycle(input bit en, input logic [15:0] pc, input bit yumi,
                             input bit we, input logic [3:0] rd, input logic [15:0] val);
    bit          have_b;
    logic [49:0] eb;
    logic [15:0] nxt;
    nxt    = m_prev + 16'd1;
    have_b = (m_mode == 2) && en && (pc != m_prev) && (pc != nxt);
    eb     = {(pc > m_prev) ? 2'd0 : 2'd1, m_cnt, m_prev, pc};
    if (yumi && m_q.size() > 0) void'(m_q.pop_front());
`ifdef TRACE_REGWR_EN
    begin
      bit          have_r;
      logic [49:0] er;
      have_r = (m_mode == 2) && en && we;
      er     = {2'd2, m_cnt, 12'd0, rd, val};
      if (have_b) begin
        model_push(eb);
        if (have_r && m_skid_v) begin m_ovf = 1'b1; m_drop++; end
        else if (have_r) begin m_skid = er; m_skid_v = 1'b1; end
      end else if (m_skid_v) begin
        model_push(m_skid);
        m_skid_v = have_r;
        if (have_r) m_skid = er;
      end else if (have_r) begin
        model_push(er);
      end
    end
`else
    if (have_b) model_push(eb);
`endif
    if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else begin
      m_prev = pc;
      m_cnt  = m_cnt + 16'd1;
      m_mode = (m_mode == 1 || en) ? 2 : 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_v"},     64'(entry_v_o),  64'(m_q.size() > 0));
    check({tag, "_entry"}, 64'(entry_o),    (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
    check({tag, "_count"}, 64'(count_o),    64'(m_q.size()));
    check({tag, "_ovf"},   64'(overflow_o), 64'(m_ovf));
    check({tag, "_drop"},  64'(drop_cnt_o), 64'((m_drop > 255) ? 255 : m_drop));
  endtask

  task automatic step(input bit en, input logic [15:0] pc, input bit yumi,
                      input bit we = 1'b0, input logic [3:0] rd = 4'd0,
                      input logic [15:0] val = 16'd0);
    trace_en_i = en; pc_i = pc; entry_yumi_i = yumi;
    rd_we_i = we; rd_i = rd; rd_val_i = val;
    model_cycle(en, pc, yumi, we, rd, val);
    @(posedge clk_i); #1;
    check_outputs("cyc");
    last_pc = pc;
  endtask

  // Leave any running capture, then arm with p as the reference PC
  task automatic arm(input logic [15:0] p);
    step(1'b0, p, 1'b0);
    step(1'b1, p, 1'b0);
    step(1'b1, p, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (m_q.size() > 0 || m_skid_v) step(1'b0, last_pc, m_q.size() > 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; entry_yumi_i = 1'b0;
    model_reset();
    @(posedge clk_i); #1;
    check("rst_v",     64'(entry_v_o),  64'd0);
    check("rst_entry", 64'(entry_o),    64'd0);
    check("rst_count", 64'(count_o),    64'd0);
    check("rst_ovf",   64'(overflow_o), 64'd0);
    check("rst_drop",  64'(drop_cnt_o), 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trace_en_i = 1'b0; pc_i = 16'd0; rd_i = 4'd0;
    rd_val_i = 16'd0; rd_we_i = 1'b0; entry_yumi_i = 1'b0; last_pc = 16'd0;
    model_reset();
    @(posedge clk_i); #1;
    do_reset();

    // 1: sequential run with a stall logs nothing
    step(1'b1, 16'd0, 1'b0); step(1'b1, 16'd1, 1'b0); step(1'b1, 16'd2, 1'b0);
    step(1'b1, 16'd3, 1'b0); step(1'b1, 16'd3, 1'b0); step(1'b1, 16'd4, 1'b0);
    check("t1_count", 64'(count_o), 64'd0);

    // 2: forward jump 14 -> 35
    arm(16'd13);
    step(1'b1, 16'd14, 1'b0);
    check("t2_v_before", 64'(entry_v_o), 64'd0);
    step(1'b1, 16'd35, 1'b0);
    check("t2_v",    64'(entry_v_o),     64'd1);
    check("t2_kind", 64'(entry_o[49:48]), 64'd0);
    check("t2_from", 64'(entry_o[31:16]), 64'd14);
    check("t2_to",   64'(entry_o[15:0]),  64'd35);

    // 3: backward jump 61 -> 46, then wrap FFFF -> 0000 is sequential
    drain();
    arm(16'd60);
    step(1'b1, 16'd61, 1'b0); step(1'b1, 16'd46, 1'b0);
    check("t3_kind", 64'(entry_o[49:48]), 64'd1);
    check("t3_from", 64'(entry_o[31:16]), 64'd61);
    check("t3_to",   64'(entry_o[15:0]),  64'd46);
    drain();
    arm(16'hFFFE);
    step(1'b1, 16'hFFFF, 1'b0); step(1'b1, 16'h0000, 1'b0);
    check("t3_wrap_count", 64'(count_o), 64'd0);
    step(1'b0, 16'h0000, 1'b1);
    check("t3_yumi_empty", 64'(count_o), 64'd0);

    // 4: ten jumps into an 8-entry FIFO with no consumer
    arm(16'd100);
    for (int k = 0; k < 10; k++) step(1'b1, (k % 2 == 0) ? 16'd200 : 16'd100, 1'b0);
    check("t4_count", 64'(count_o),    64'd8);
    check("t4_ovf",   64'(overflow_o), 64'd1);
    check("t4_drop",  64'(drop_cnt_o), 64'd2);
    step(1'b1, 16'd300, 1'b1);
    check("t4_full_yumi_count", 64'(count_o),    64'd8);
    check("t4_full_yumi_drop",  64'(drop_cnt_o), 64'd2);

    // 5: reset in the middle of draining
    for (int k = 0; k < 3; k++) step(1'b0, last_pc, 1'b1);
    check("t5_count5", 64'(count_o), 64'd5);
    trace_en_i = 1'b1;
    do_reset();
    step(1'b1, 16'd500, 1'b0); step(1'b1, 16'd900, 1'b0); step(1'b1, 16'd901, 1'b0);
    check("t5_arm_count", 64'(count_o), 64'd0);

    // 6: branch and register write in the same cycle
    arm(16'd13);
    step(1'b1, 16'd14, 1'b0);
    step(1'b1, 16'd35, 1'b0, 1'b1, 4'd3, 16'h0024);
    check("t6_br_kind", 64'(entry_o[49:48]), 64'd0);
    step(1'b1, 16'd36, 1'b0);
`ifdef TRACE_REGWR_EN
    check("t6_count", 64'(count_o), 64'd2);
    step(1'b1, 16'd37, 1'b1);
    check("t6_rw_kind", 64'(entry_o[49:48]), 64'd2);
    check("t6_rw_from", 64'(entry_o[31:16]), 64'd3);
    check("t6_rw_to",   64'(entry_o[15:0]),  64'h24);
`else
    check("t6_count", 64'(count_o), 64'd1);
`endif
    drain();

    // Randomized traffic: light draining first, then heavy draining
    for (int i = 0; i < 800; i++) begin
      int          r;
      logic [15:0] np;
      bit          en, yumi, we;
      r = int'($urandom_range(0, 99));
      if (r < 45)      np = last_pc + 16'd1;
      else if (r < 60) np = last_pc;
      else if (r < 65) np = 16'hFFFF;
      else             np = 16'($urandom);
      en   = ($urandom_range(0, 19) != 0);
      yumi = (m_q.size() > 0) && ($urandom_range(0, 3) < ((i < 400) ? 1 : 3));
      we   = ($urandom_range(0, 2) == 0);
      step(en, np, yumi, we, 4'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
